uart_axi4l_regs: RTL

//   AXI4-Lite slave register block fronting the UART TX/RX datapaths. Decodes a

---
 rtl/uart_axi4l_regs.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_axi4l_regs.sv
// AXI4-Lite register block for the UART: SCRATCH, CTRL, STATUS, TX_DATA, RX_DATA
// inside a base/mask address window, bridged to byte-wide TX/RX valid/ready streams.
module uart_axi4l_regs #(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]  AXI_BASE_ADDR  = 'h8000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]  AXI_BASE_MASK  = 'h0000_0FFF,
  parameter bit                         RX_ENABLE      = 1'b1,
  parameter bit                         TX_ENABLE      = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  input  logic                          rx_overrun,
  output logic                          tx_en,
  output logic                          rx_en
);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_SCRATCH = 'h00;
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_CTRL    = 'h04;
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_STATUS  = 'h08;
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_TXDATA  = 'h0C;
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_RXDATA  = 'h10;

  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a & ~AXI_BASE_MASK) == AXI_BASE_ADDR;
  endfunction

  w_state_e                     w_state_q, w_state_d;
  r_state_e                     r_state_q, r_state_d;
  logic                         aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [AXI_ADDR_WIDTH-1:0]    awaddr_q, awaddr_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic                         awready_q, awready_d, wready_q, wready_d;
  logic                         bvalid_q, bvalid_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic                         arready_q, arready_d, rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;
  logic [31:0]                  scratch_q, scratch_d;
  logic [1:0]                   ctrl_q, ctrl_d;
  logic                         overrun_q, overrun_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         tx_valid_q, tx_valid_d;

  logic                         aw_hs, w_hs, ar_hs, ovr_clr, rx_pop, rx_valid_i;
  logic [AXI_ADDR_WIDTH-1:0]    wr_addr, wr_off, rd_off;
  logic [31:0]                  wr_data, rd32;
  logic [3:0]                   wr_strb;

  assign rx_valid_i = RX_ENABLE && rx_valid;

  // A channel captured in an earlier cycle is replayed from its holding register.
  always_comb begin
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    scratch_d  = scratch_q;
    ctrl_d     = ctrl_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q && !tx_ready;
    ovr_clr    = 1'b0;
    aw_hs      = s_axi_awvalid && awready_q;
    w_hs       = s_axi_wvalid && wready_q;
    wr_addr    = aw_got_q ? awaddr_q : s_axi_awaddr;
    wr_data    = w_got_q ? wdata_q : s_axi_wdata[31:0];
    wr_strb    = w_got_q ? wstrb_q : s_axi_wstrb[3:0];
    wr_off     = wr_addr & AXI_BASE_MASK;
    if (aw_hs) begin
      aw_got_d = 1'b1;
      awaddr_d = s_axi_awaddr;
    end
    if (w_hs) begin
      w_got_d = 1'b1;
      wdata_d = s_axi_wdata[31:0];
      wstrb_d = s_axi_wstrb[3:0];
    end
    case (w_state_q)
      W_IDLE: begin
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          bresp_d   = RESP_SLVERR;
          if (!in_window(wr_addr)) begin
            bresp_d = RESP_DECERR;
          end else begin
            case (wr_off)
              OFF_SCRATCH: begin
                for (int unsigned b = 0; b < 4; b++)
                  if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
                bresp_d = RESP_OKAY;
              end
              OFF_CTRL: begin
                if (wr_strb[0]) ctrl_d = wr_data[1:0] & {RX_ENABLE, TX_ENABLE};
                bresp_d = RESP_OKAY;
              end
              OFF_STATUS: begin
                ovr_clr = wr_strb[0] && wr_data[2];
                bresp_d = RESP_OKAY;
              end
              OFF_TXDATA: begin
                if (TX_ENABLE && ctrl_q[0] && !tx_valid_q && wr_strb[0]) begin
                  tx_data_d  = wr_data[7:0];
                  tx_valid_d = 1'b1;
                  bresp_d    = RESP_OKAY;
                end
              end
              default: ;
            endcase
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    // A receiver overrun in the same cycle as a W1C clear must not be lost.
    overrun_d = (overrun_q && !ovr_clr) || rx_overrun;
    awready_d = (w_state_d == W_IDLE) && !aw_got_d;
    wready_d  = (w_state_d == W_IDLE) && !w_got_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rx_pop    = 1'b0;
    rd32      = '0;
    ar_hs     = s_axi_arvalid && arready_q;
    rd_off    = s_axi_araddr & AXI_BASE_MASK;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rresp_d   = RESP_SLVERR;
          if (!in_window(s_axi_araddr)) begin
            rresp_d = RESP_DECERR;
          end else begin
            case (rd_off)
              OFF_SCRATCH: begin rd32 = scratch_q; rresp_d = RESP_OKAY; end
              OFF_CTRL:    begin rd32 = {30'b0, ctrl_q}; rresp_d = RESP_OKAY; end
              OFF_STATUS:  begin
                rd32    = {29'b0, overrun_q, rx_valid_i, !tx_valid_q};
                rresp_d = RESP_OKAY;
              end
              OFF_RXDATA: begin
                if (rx_valid_i && ctrl_q[1]) begin
                  rd32    = {24'b0, rx_data};
                  rx_pop  = 1'b1;
                  rresp_d = RESP_OKAY;
                end
              end
              default: ;
            endcase
          end
          rdata_d       = '0;
          rdata_d[31:0] = rd32;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      scratch_q  <= '0;
      ctrl_q     <= '0;
      overrun_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      overrun_q  <= overrun_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign rx_ready      = rx_pop;
  assign tx_en         = ctrl_q[0];
  assign rx_en         = ctrl_q[1];

endmodule
